// File: rtl/abus_rr.sv
// N-master bus arbiter: fixed-priority or round-robin selection with a bounded
// hold time, one-cycle registered grant and zero-bubble handover.
module abus_rr #(
  parameter int unsigned N        = 8,
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mode,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_id,
  output logic                 grant_valid
);

  localparam int unsigned IW = $clog2(N);
  localparam int unsigned CW = IW + 1;
  localparam int unsigned HW = $clog2(MAX_HOLD + 1);

  logic [HW-1:0] hold_cnt;
  logic [HW-1:0] hold_nxt;
  logic [IW-1:0] last_id;
  logic [IW-1:0] last_nxt;
  logic [N-1:0]  grant_nxt;
  logic [IW-1:0] id_nxt;
  logic          valid_nxt;
  logic [N-1:0]  eligible;
  logic          owner_req;
  logic          competing;
  logic          expired;
  logic          found;
  logic [IW-1:0] pick;
  logic [CW-1:0] cand;

  // Next-state: keep the owner while it requests, otherwise arbitrate.
  // An expired owner facing competition is removed from the candidate set.
  always_comb begin
    owner_req = grant_valid & req[grant_id];
    competing = |(req & ~grant);
    expired   = (hold_cnt >= HW'(MAX_HOLD));
    eligible  = req;
    found     = 1'b0;
    pick      = '0;
    cand      = '0;
    grant_nxt = grant;
    id_nxt    = grant_id;
    valid_nxt = grant_valid;
    hold_nxt  = hold_cnt;
    last_nxt  = last_id;

    if (owner_req && !(expired && competing)) begin
      hold_nxt = expired ? HW'(1) : hold_cnt + HW'(1);
    end else begin
      if (owner_req) eligible[grant_id] = 1'b0;
      // Round-robin search starts after last_id and wraps at N-1, not at 2**IW-1.
      for (int unsigned i = 0; i < N; i++) begin
        if (mode) begin
          cand = CW'(last_id) + CW'(i) + CW'(1);
          if (cand >= CW'(N)) cand = cand - CW'(N);
        end else begin
          cand = CW'(i);
        end
        if (!found && eligible[IW'(cand)]) begin
          found = 1'b1;
          pick  = IW'(cand);
        end
      end
      grant_nxt = '0;
      if (found) begin
        grant_nxt[pick] = 1'b1;
        last_nxt        = pick;
      end
      id_nxt    = found ? pick : '0;
      valid_nxt = found;
      hold_nxt  = found ? HW'(1) : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant       <= '0;
      grant_id    <= '0;
      grant_valid <= 1'b0;
      hold_cnt    <= '0;
      last_id     <= IW'(N - 1);
    end else begin
      grant       <= grant_nxt;
      grant_id    <= id_nxt;
      grant_valid <= valid_nxt;
      hold_cnt    <= hold_nxt;
      last_id     <= last_nxt;
    end
  end

endmodule

// File: tb/tb_abus_rr.sv
// Bench for abus_rr (N=8, MAX_HOLD=4): directed scenarios plus random traffic
// compared against an owner/hold/last-id reference model.
module tb_abus_rr;

  localparam int N        = 8;
  localparam int MAX_HOLD = 4;

  logic         clk;
  logic         rst_n;
  logic         mode;
  logic [N-1:0] req;
  logic [N-1:0] grant;
  logic [2:0]   grant_id;
  logic         grant_valid;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int m_owner;
  int m_hold;
  int m_last;

  int cnt [N];

  abus_rr #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mode        (mode),
    .req         (req),
    .grant       (grant),
    .grant_id    (grant_id),
    .grant_valid (grant_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_owner = -1;
    m_hold  = 0;
    m_last  = N - 1;
  endfunction

  // Apply the arbitration rules to the inputs sampled at this edge.
  function automatic void model_edge(input logic md, input logic [N-1:0] r);
    bit owner_on;
    bit others;
    int excl;
    int pk;
    int c;
    owner_on = (m_owner >= 0) && r[3'(m_owner)];
    others   = 1'b0;
    for (int k = 0; k < N; k++)
      if (r[3'(k)] && k != m_owner) others = 1'b1;
    if (owner_on && !(m_hold >= MAX_HOLD && others)) begin
      m_hold = (m_hold >= MAX_HOLD) ? 1 : m_hold + 1;
    end else begin
      excl = owner_on ? m_owner : -1;
      pk   = -1;
      for (int k = 0; k < N; k++) begin
        c = md ? (m_last + 1 + k) % N : k;
        if (pk < 0 && r[3'(c)] && c != excl) pk = c;
      end
      if (pk >= 0) begin
        m_owner = pk;
        m_hold  = 1;
        m_last  = pk;
      end else begin
        m_owner = -1;
        m_hold  = 0;
      end
    end
  endfunction

  task automatic check_outputs();
    int exp_g;
    int ones;
    int idx;
    exp_g = (m_owner >= 0) ? (1 << m_owner) : 0;
    check("grant", grant, exp_g);
    check("grant_id", grant_id, (m_owner >= 0) ? m_owner : 0);
    check("grant_valid", grant_valid, (m_owner >= 0) ? 1 : 0);
    ones = 0;
    idx  = 0;
    for (int k = 0; k < N; k++)
      if (grant[3'(k)]) begin
        ones++;
        idx = k;
      end
    check("onehot0", (ones <= 1) ? 1 : 0, 1);
    check("valid_consistent", grant_valid, (ones != 0) ? 1 : 0);
    check("id_consistent", grant_id, idx);
  endtask

  // One clock: sample away from the edge, advance the model, compare.
  task automatic step();
    logic         md;
    logic [N-1:0] r;
    md = mode;
    r  = req;
    @(posedge clk);
    #1;
    model_edge(md, r);
    check_outputs();
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_grant", grant, 0);
    check("rst_valid", grant_valid, 0);
    check("rst_id", grant_id, 0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [N-1:0] v;
    int           lowest;
    rst_n = 1'b1;
    mode  = 1'b0;
    req   = '0;
    model_reset();
    #1;
    do_reset();

    // Fixed priority, every request value for one cycle
    mode = 1'b0;
    for (int i = 0; i < 256; i++) begin
      v   = 8'(i);
      req = v;
      step();
      lowest = i & (-i);
      check("prio_lowest", grant, lowest);
      req = '0;
      step();
      check("prio_clear", grant, 0);
    end

    // Round-robin, all requesting: 4 cycles each, equal share
    do_reset();
    mode = 1'b1;
    req  = 8'hFF;
    for (int k = 0; k < N; k++) cnt[k] = 0;
    for (int c = 0; c < 64; c++) begin
      step();
      if (c == 0) check("rr_first", grant, 8'h01);
      if (c == 4) check("rr_second", grant, 8'h02);
      if (c == 32) check("rr_wrap", grant, 8'h01);
      for (int k = 0; k < N; k++) if (grant[3'(k)]) cnt[k]++;
    end
    for (int k = 0; k < N; k++) check("rr_share", cnt[k], 8);

    // Fixed priority preemption on two requesters
    do_reset();
    mode = 1'b0;
    req  = 8'h03;
    for (int c = 0; c < 12; c++) begin
      step();
      check("preempt_seq", grant, (c >= 4 && c < 8) ? 8'h02 : 8'h01);
    end

    // Zero-bubble handover from master 7 to master 0
    do_reset();
    mode = 1'b1;
    req  = 8'h80;
    step();
    check("handover_own7", grant_id, 7);
    req = 8'h81;
    step();
    check("handover_hold7", grant, 8'h80);
    req = 8'h01;
    step();
    check("handover_to0", grant, 8'h01);
    check("handover_valid", grant_valid, 1);

    // Lone requester held past MAX_HOLD, then release
    req = 8'h10;
    for (int c = 0; c < 10; c++) begin
      step();
      check("single_grant", grant, 8'h10);
      check("single_id", grant_id, 4);
    end
    req = '0;
    step();
    check("single_drop", grant, 0);

    // Asynchronous reset mid-hold, then round-robin restarts at master 0
    mode = 1'b1;
    req  = 8'hFF;
    step();
    step();
    do_reset();
    step();
    check("post_rst_first", grant, 8'h01);

    // Random traffic with occasional mode flips
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 49) == 0) mode = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0: req = 8'($urandom);
        1: req = 8'($urandom) & 8'($urandom) & 8'($urandom);
        2: req = '0;
        default: ;
      endcase
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/abus_rr.md
ABUS_RR -- requirements
Module: abus_rr

Interface
REQ-001 SHALL have parameter N, default 8, number of masters (N >= 2).
REQ-002 SHALL have parameter MAX_HOLD, default 16, maximum consecutive grant cycles while competitors are pending (MAX_HOLD >= 1).
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port mode  input  1  arbitration mode: 0 = lower-first fixed priority, 1 = round-robin.
REQ-006 SHALL have port req  input  N  per-master request, level-sensitive.
REQ-007 SHALL have port grant  output  N  registered grant, one-hot or all-zero.
REQ-008 SHALL have port grant_id  output  $clog2(N)  binary index of the granted master.
REQ-009 SHALL have port grant_valid  output  1  high when any grant bit is set.

Function
REQ-010 SHALL register all outputs; a request sampled at rising edge k SHALL yield its grant after edge k, so latency is one cycle.
REQ-011 SHALL drive grant_valid = |grant, and grant_id = index of the set grant bit (0 when grant_valid = 0).
REQ-012 SHALL keep grant one-hot-or-zero at all times; grant[i] = 1 SHALL imply req[i] was 1 at the preceding edge.
REQ-013 SHALL arbitrate at an edge when any of these holds: no current owner; owner req low; owner hold expired (REQ-017).
REQ-014 SHALL pick, in mode 0, the lowest-index eligible requester.
REQ-015 SHALL pick, in mode 1, the first eligible requester searching from last_id+1 upward and wrapping modulo N.
REQ-016 SHALL keep last_id = index of the most recent new grant; it updates only when ownership changes.
REQ-017 SHALL hold the owner while its req stays high; hold counter counts held cycles; when it reaches MAX_HOLD and another req bit is set, the owner is excluded from that arbitration (preemption in both modes).
REQ-018 SHALL, on hold expiry with no competing request, keep the owner and restart the hold counter at 1.
REQ-019 SHALL clear the hold counter to 1 on every ownership change.
REQ-020 SHALL hand over with zero bubble: when owner req drops and another req is set, the new grant appears on the same edge the old one clears.
REQ-021 SHALL drive grant to zero on the edge after the owner drops req if no other req is set.
REQ-022 SHALL apply a mode change only at the next arbitration; a current owner is never preempted by a mode change.
REQ-023 SHALL leave N not a power of two legal; round-robin wrap SHALL be at N-1, never at 2**$clog2(N)-1.

Reset
REQ-024 SHALL, on rst_n low, asynchronously clear grant, grant_id, grant_valid and the hold counter to 0 and set last_id to N-1.
REQ-025 SHALL drop any grant immediately on reset assertion, including mid-hold.
REQ-026 SHALL allow the first grant at the first rising edge after rst_n deasserts; after reset, mode 1 behaves as lowest-first for the first grant.

Verification (N=8, MAX_HOLD=4)
REQ-027 SHALL cover: mode 0, req = 0..255, each value held one cycle then cleared -> grant = lowest set bit one cycle later, 0 for req=0.
REQ-028 SHALL cover: mode 1, req = 8'hFF constant after reset -> grant 01 for 4 cycles, then 02, 04, ... 80 for 4 cycles each, then 01; each master granted an equal count.
REQ-029 SHALL cover: mode 0, req = 8'h03 constant -> grant 01 for 4 cycles, 02 for 4 cycles, 01 again (preemption, no starvation of bit 1).
REQ-030 SHALL cover: mode 1, owner bit 7, req goes 8'h81 -> 8'h01 -> grant 80 -> 01 on the next edge, grant_valid never low, grant_id 7 -> 0.
REQ-031 SHALL cover: single req = 8'h10 for 10 cycles -> grant = 10 for all 10 cycles, grant_id = 4; req cleared -> grant = 0 next edge.
REQ-032 SHALL cover: rst_n pulsed low mid-hold -> grant = 0 and grant_valid = 0 without a clock edge; after release with mode 1 and req = 8'hFF -> first grant 01.
REQ-033 SHALL check on every cycle of every scenario: grant one-hot-or-zero and REQ-011 consistency.
